// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares one DBus between the store drain (S) and the load path (L).
// In-order responses are routed through an ID FIFO. Define DBUS_ARB_PERF_EN to add perf counters.
module dbus_arbiter #(
  parameter int OUTSTANDING     = 2,
  parameter int STORE_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        s_req,
  input  logic [3:0]  s_wstrb,
  input  logic [2:0]  s_size,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic        s_addr_ok,
  output logic        s_data_ok,
  input  logic        l_req,
  input  logic [2:0]  l_size,
  input  logic [31:0] l_addr,
  output logic        l_addr_ok,
  output logic        l_data_ok,
  output logic [31:0] l_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [3:0]  m_wstrb,
  output logic [2:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
`ifdef DBUS_ARB_PERF_EN
  ,
  output logic [31:0] perf_store_cnt,
  output logic [31:0] perf_load_cnt,
  output logic [31:0] perf_cancel_cnt
`endif
);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int BW = $clog2(STORE_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(STORE_BURST_MAX);

  typedef enum logic [1:0] {IDLE, HOLD_S, HOLD_L} state_t;
  typedef enum logic [1:0] {G_NONE, G_S, G_L} grant_t;
  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t state, state_nxt;
  grant_t grant;
  req_t   mux;

  logic [PW-1:0]          wr_idx, rd_idx;
  logic                   wr_wrap, rd_wrap;
  logic [OUTSTANDING-1:0] ent_l, ent_cancel;
  logic [BW-1:0]          burst;
  logic fifo_full, fifo_empty, push, pop, head_l, head_cancel;

  function automatic logic [PW:0] bump(input logic [PW-1:0] idx, input logic wrap);
    if (idx == PW'(OUTSTANDING - 1)) return {~wrap, PW'(0)};
    return {wrap, idx + PW'(1)};
  endfunction

  assign fifo_empty  = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
  assign fifo_full   = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
  assign head_l      = ent_l[rd_idx];
  assign head_cancel = ent_cancel[rd_idx];

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;

  // grant is gated by resetn so every request output reads 0 while reset is held
  always_comb begin
    grant = G_NONE;
    if (resetn) begin
      case (state)
        IDLE: if (!fifo_full) begin
          if (s_req && !(l_req && burst == BURST_MAX)) grant = G_S;
          else if (l_req && !flush)                    grant = G_L;
        end
        HOLD_S:  grant = G_S;
        HOLD_L:  grant = flush ? G_NONE : G_L;
        default: grant = G_NONE;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant == G_S && !m_addr_ok) state_nxt = HOLD_S;
        if (grant == G_L && !m_addr_ok) state_nxt = HOLD_L;
      end
      HOLD_S:  if (m_addr_ok) state_nxt = IDLE;
      HOLD_L:  if (m_addr_ok || flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mux = '0;
    case (grant)
      G_S:     mux = '{wr: 1'b1, wstrb: s_wstrb, size: s_size, addr: s_addr, wdata: s_wdata};
      G_L:     mux = '{wr: 1'b0, wstrb: 4'b0, size: l_size, addr: l_addr, wdata: 32'b0};
      default: mux = '0;
    endcase
  end

  assign m_req     = (grant != G_NONE);
  assign m_wr      = mux.wr;
  assign m_wstrb   = mux.wstrb;
  assign m_size    = mux.size;
  assign m_addr    = mux.addr;
  assign m_wdata   = mux.wdata;
  assign s_addr_ok = m_addr_ok && grant == G_S;
  assign l_addr_ok = m_addr_ok && grant == G_L;

  assign push      = m_req && m_addr_ok;
  assign pop       = m_data_ok && !fifo_empty;
  assign s_data_ok = pop && !head_l;
  assign l_data_ok = pop && head_l && !head_cancel;
  assign l_rdata   = m_rdata;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_idx     <= '0;
      wr_wrap    <= 1'b0;
      rd_idx     <= '0;
      rd_wrap    <= 1'b0;
      ent_l      <= '0;
      ent_cancel <= '0;
      burst      <= '0;
    end else begin
      if (push) {wr_wrap, wr_idx} <= bump(wr_idx, wr_wrap);
      if (pop)  {rd_wrap, rd_idx} <= bump(rd_idx, rd_wrap);
      // stale slots may get marked too; a push rewrites its slot's cancel bit
      for (int i = 0; i < OUTSTANDING; i++)
        if (flush && ent_l[i]) ent_cancel[i] <= 1'b1;
      if (push) begin
        ent_l[wr_idx]      <= (grant == G_L);
        ent_cancel[wr_idx] <= (grant == G_L) && flush;
      end
      if (!l_req)                                     burst <= '0;
      else if (push && grant == G_L)                  burst <= '0;
      else if (push && grant == G_S && burst != BURST_MAX) burst <= burst + BW'(1);
    end

`ifdef DBUS_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      perf_store_cnt  <= '0;
      perf_load_cnt   <= '0;
      perf_cancel_cnt <= '0;
    end else begin
      if (push && grant == G_S)          perf_store_cnt  <= perf_store_cnt + 32'd1;
      if (push && grant == G_L)          perf_load_cnt   <= perf_load_cnt + 32'd1;
      if (pop && head_l && head_cancel)  perf_cancel_cnt <= perf_cancel_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: queue-based transaction model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_dbus_arbiter;
  localparam int OUT = 2;
  localparam int BMAX = 4;

  logic        clk = 1'b0;
  logic        resetn, flush;
  logic        s_req, l_req;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_size, l_size;
  logic [31:0] s_addr, s_wdata, l_addr;
  logic        s_addr_ok, s_data_ok, l_addr_ok, l_data_ok;
  logic [31:0] l_rdata;
  logic        m_req, m_wr;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.OUTSTANDING(OUT), .STORE_BURST_MAX(BMAX)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .s_req(s_req), .s_wstrb(s_wstrb), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
    .l_req(l_req), .l_size(l_size), .l_addr(l_addr),
    .l_addr_ok(l_addr_ok), .l_data_ok(l_data_ok), .l_rdata(l_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model: in-flight queue of {is_load, cancelled}, a locked port
  // (request presented but not yet accepted) and the store-burst count.
  typedef struct { bit l; bit c; } ent_t;

  initial begin : model
    ent_t q[$];
    int   lock, burst, g;
    bit   full, acc, popv;
    lock = 0; burst = 0;
    forever begin
      @(negedge clk);
      g = 0;
      full = (q.size() == OUT);
      if (resetn === 1'b1) begin
        if (lock == 1)      g = 1;
        else if (lock == 2) g = flush ? 0 : 2;
        else if (!full) begin
          if (s_req && !(l_req && burst == BMAX)) g = 1;
          else if (l_req && !flush)              g = 2;
        end
      end else begin
        q.delete(); lock = 0; burst = 0;
      end
      popv = resetn && m_data_ok && q.size() > 0;
      chk("m_req",     m_req,     g != 0);
      chk("m_wr",      m_wr,      g == 1);
      chk("m_wstrb",   m_wstrb,   g == 1 ? s_wstrb : 4'h0);
      chk("m_size",    m_size,    g == 1 ? s_size : g == 2 ? l_size : 3'h0);
      chk("m_addr",    m_addr,    g == 1 ? s_addr : g == 2 ? l_addr : 32'h0);
      chk("m_wdata",   m_wdata,   g == 1 ? s_wdata : 32'h0);
      chk("s_addr_ok", s_addr_ok, m_addr_ok && g == 1);
      chk("l_addr_ok", l_addr_ok, m_addr_ok && g == 2);
      chk("s_data_ok", s_data_ok, popv && !q[0].l);
      chk("l_data_ok", l_data_ok, popv && q[0].l && !q[0].c);
      chk("l_rdata",   l_rdata,   m_rdata);
      @(posedge clk);
      if (resetn !== 1'b1) begin
        q.delete(); lock = 0; burst = 0;
      end else begin
        acc = (g != 0) && m_addr_ok;
        if (flush) foreach (q[i]) if (q[i].l) q[i].c = 1'b1;
        if (popv) void'(q.pop_front());
        if (acc) q.push_back('{l: (g == 2), c: (g == 2) && flush});
        lock = acc ? 0 : g;
        if (!l_req)              burst = 0;
        else if (acc && g == 2)  burst = 0;
        else if (acc && g == 1 && burst < BMAX) burst++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin : drive
    bit exp_wr [7] = '{1, 1, 1, 1, 0, 1, 1};
    int ns;
    resetn = 1'b0; flush = 1'b0; s_req = 1'b0; l_req = 1'b0;
    s_wstrb = 4'h0; s_size = 3'd0; s_addr = 32'h0; s_wdata = 32'h0;
    l_size = 3'd0; l_addr = 32'h0; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
    step(); step();
    chk("rst m_req", m_req, 1'b0);
    chk("rst m_addr", m_addr, 32'h0);
    chk("rst l_data_ok", l_data_ok, 1'b0);
    resetn = 1'b1;
    step();

    // load only, response two cycles after accept
    l_req = 1'b1; l_addr = 32'h40; l_size = 3'd2; m_addr_ok = 1'b1; #1;
    chk("ld l_addr_ok", l_addr_ok, 1'b1);
    chk("ld m_wr", m_wr, 1'b0);
    step(); l_req = 1'b0; m_addr_ok = 1'b0;
    step();
    m_data_ok = 1'b1; m_rdata = 32'h12345678; #1;
    chk("ld l_data_ok", l_data_ok, 1'b1);
    chk("ld l_rdata", l_rdata, 32'h12345678);
    chk("ld s_data_ok", s_data_ok, 1'b0);
    step(); m_data_ok = 1'b0;

    // simultaneous S and L: S first, L next, responses in order
    s_req = 1'b1; s_addr = 32'h100; s_wdata = 32'hCAFE0001; s_wstrb = 4'hF; s_size = 3'd2;
    l_req = 1'b1; l_addr = 32'h200; m_addr_ok = 1'b1; #1;
    chk("both m_wr", m_wr, 1'b1);
    chk("both m_addr S", m_addr, 32'h100);
    step(); s_req = 1'b0; #1;
    chk("both m_addr L", m_addr, 32'h200);
    chk("both l_addr_ok", l_addr_ok, 1'b1);
    step(); l_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hAAAA0001; #1;
    chk("both s_data_ok", s_data_ok, 1'b1);
    chk("both l_data_ok0", l_data_ok, 1'b0);
    step(); m_rdata = 32'hBBBB0002; #1;
    chk("both l_data_ok1", l_data_ok, 1'b1);
    step(); m_data_ok = 1'b0;

    // store burst limit: 4 stores, the waiting load, then the last 2 stores
    ns = 0;
    s_req = 1'b1; l_req = 1'b1; l_addr = 32'h300; m_addr_ok = 1'b1;
    for (int k = 0; k < 7; k++) begin
      s_addr = 32'h1000 + 32'(4 * ns);
      m_data_ok = (k > 0); m_rdata = 32'h3000 + 32'(k); #1;
      chk($sformatf("burst m_wr[%0d]", k), m_wr, exp_wr[k]);
      step();
      if (exp_wr[k]) ns++; else l_req = 1'b0;
    end
    chk("burst stores", ns, 6);
    s_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    step(); m_data_ok = 1'b0;

    // flush: blocks an IDLE load, cancels an in-flight load, drops HOLD_L
    l_req = 1'b1; l_addr = 32'h500; flush = 1'b1; m_addr_ok = 1'b1; #1;
    chk("flush idle m_req", m_req, 1'b0);
    step(); flush = 1'b0; #1;
    chk("flush ld accept", l_addr_ok, 1'b1);
    step(); l_req = 1'b0; m_addr_ok = 1'b0; flush = 1'b1;
    step(); flush = 1'b0;
    s_req = 1'b1; s_addr = 32'h600; s_wdata = 32'h0600; m_addr_ok = 1'b1; #1;
    chk("flush st accept", s_addr_ok, 1'b1);
    step(); s_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hDEAD0000; #1;
    chk("flush l_data_ok", l_data_ok, 1'b0);
    step(); #1;
    chk("flush s_data_ok", s_data_ok, 1'b1);
    step(); m_data_ok = 1'b0;
    l_req = 1'b1; l_addr = 32'h580;
    step(); flush = 1'b1; #1;
    chk("hold_l flush m_req", m_req, 1'b0);
    step(); flush = 1'b0; l_req = 1'b0;
    s_req = 1'b1; s_addr = 32'h900;
    step(); flush = 1'b1; m_addr_ok = 1'b1; #1;
    chk("hold_s flush m_wr", m_wr, 1'b1);
    chk("hold_s s_addr_ok", s_addr_ok, 1'b1);
    step(); flush = 1'b0; s_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; #1;
    chk("hold_s s_data_ok", s_data_ok, 1'b1);
    step(); m_data_ok = 1'b0;

    // FIFO full stalls the grant until a pop
    s_req = 1'b1; s_addr = 32'h700; m_addr_ok = 1'b1;
    step(); s_req = 1'b0; l_req = 1'b1; l_addr = 32'h704;
    step(); l_req = 1'b0; s_req = 1'b1; s_addr = 32'h708; #1;
    chk("full m_req", m_req, 1'b0);
    chk("full s_addr_ok", s_addr_ok, 1'b0);
    step(); m_data_ok = 1'b1; m_rdata = 32'h55; #1;
    chk("full pop m_req", m_req, 1'b0);
    chk("full pop s_data_ok", s_data_ok, 1'b1);
    step(); m_data_ok = 1'b0; #1;
    chk("full regrant m_req", m_req, 1'b1);
    step(); s_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h66; #1;
    chk("full l_data_ok", l_data_ok, 1'b1);
    step(); step(); m_data_ok = 1'b0;

    // async reset while in HOLD_L with a store in flight
    s_req = 1'b1; s_addr = 32'h800; m_addr_ok = 1'b1;
    step(); s_req = 1'b0; l_req = 1'b1; l_addr = 32'h804; m_addr_ok = 1'b0;
    step(); #1;
    chk("hold_l m_addr", m_addr, 32'h804);
    resetn = 1'b0; m_addr_ok = 1'b1; m_data_ok = 1'b1; #1;
    chk("arst m_req", m_req, 1'b0);
    chk("arst m_addr", m_addr, 32'h0);
    chk("arst l_addr_ok", l_addr_ok, 1'b0);
    chk("arst s_data_ok", s_data_ok, 1'b0);
    step(); l_req = 1'b0; m_addr_ok = 1'b0; resetn = 1'b1; m_rdata = 32'h77; #1;
    chk("stray s_data_ok", s_data_ok, 1'b0);
    chk("stray l_data_ok", l_data_ok, 1'b0);
    step(); m_data_ok = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single SRAM-like data bus (DBus) between two requesters: the store-buffer drain (port S, writes only) and the AGU load path (port L, reads only).
- Grants one request at a time and holds the grant stable until addr_ok. Tracks in-flight transactions in an ID FIFO and routes each data_ok/rdata back to the requester that issued it.
- On pipeline flush, drops responses to loads that are still in flight. Committed stores are never cancelled.
- Sits between the AGU/store-buffer logic and the dcache.

Parameters:
- OUTSTANDING, 2, max in-flight transactions (accepted, data_ok pending); power of 2, at least 1.
- STORE_BURST_MAX, 4, consecutive store grants allowed while a load waits; after that, load gets priority once.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- flush  input  1  pipeline flush; cancels pending and in-flight loads
- s_req  input  1  store drain request; held until s_addr_ok
- s_wstrb  input  4  byte strobe
- s_size  input  3  0=byte, 1=half, 2=word
- s_addr  input  32  address
- s_wdata  input  32  write data
- s_addr_ok  output  1  store request accepted
- s_data_ok  output  1  store write completed
- l_req  input  1  load request; held until l_addr_ok or flush
- l_size  input  3  load size
- l_addr  input  32  load address
- l_addr_ok  output  1  load accepted
- l_data_ok  output  1  load data valid
- l_rdata  output  32  load data
- m_req  output  1  DBus request
- m_wr  output  1  1=write (store)
- m_wstrb  output  4  strobe; 0 for loads
- m_size  output  3  size of granted request
- m_addr  output  32  address of granted request
- m_wdata  output  32  write data
- m_addr_ok  input  1  DBus accept
- m_data_ok  input  1  DBus response, in issue order
- m_rdata  input  32  read data

Behaviour:
- Reset (async, resetn=0) values:
  - State is IDLE; ID FIFO is empty; burst counter is 0.
  - m_req, s_addr_ok, l_addr_ok, s_data_ok and l_data_ok are all 0.
  - m_wr, m_wstrb, m_size, m_addr and m_wdata are 0.
- FSM states: IDLE, HOLD_S, HOLD_L. The grant is combinational from IDLE (zero added latency).
- IDLE:
  - If the FIFO is full, m_req=0 and nothing is granted.
  - Otherwise the grant is S if s_req and not (l_req and burst==STORE_BURST_MAX); else L if l_req and not flush.
  - m_req=1 with the mux outputs of the granted port.
  - If m_addr_ok arrives in the same cycle, stay in IDLE; otherwise go to HOLD_S or HOLD_L.
- HOLD_x:
  - Grant is locked to x and m_req=1 regardless of FIFO state; the FIFO was not full at grant time.
  - Return to IDLE on m_addr_ok.
  - HOLD_L also returns to IDLE on flush, with m_req deasserted in the same cycle.
  - HOLD_S ignores flush.
- addr_ok routing: s_addr_ok = m_addr_ok and grant==S; l_addr_ok = m_addr_ok and grant==L.
- FIFO push and entry format:
  - Push on m_req and m_addr_ok.
  - Entry is {src, cancel}; cancel = (src==L and flush).
- FIFO pop: on m_data_ok.
  - s_data_ok = m_data_ok and head.src==S.
  - l_data_ok = m_data_ok and head.src==L and not head.cancel.
  - l_rdata = m_rdata (passthrough).
- Flush: sets cancel on every valid L entry, in the same cycle as any push.
- Simultaneous push and pop: FIFO occupancy is unchanged. Full and empty are computed with a pointer and wrap bit.
- m_data_ok with an empty FIFO is ignored; nothing is forwarded.
- Burst counter:
  - Increments on an accepted S while l_req=1, saturating at STORE_BURST_MAX.
  - Clears on an accepted L or when l_req=0.

Optional Feature:
DBUS_ARB_PERF_EN:
- When defined, adds outputs perf_store_cnt[31:0], perf_load_cnt[31:0] and perf_cancel_cnt[31:0].
- These count accepted stores, accepted loads and dropped load responses respectively.
- Each counter wraps at 2^32 and resets to 0.
- When not defined, these ports and counters do not exist.

Test Plan:
- Load only, m_addr_ok same cycle, m_data_ok 2 cycles later with m_rdata=0x12345678 -> l_addr_ok 1 cycle; l_data_ok=1 and l_rdata=0x12345678; s_data_ok stays 0.
- s_req and l_req asserted together at addr 0x100 (S) and 0x200 (L) -> S granted first (m_wr=1, m_addr=0x100); L granted on the next IDLE cycle; responses routed in order.
- s_req held high for 6 transactions while l_req is high, STORE_BURST_MAX=4 -> 4 stores accepted, then the load, then the remaining stores.
- Load accepted, then flush before m_data_ok -> l_data_ok stays 0 on the response; FIFO empties; a following store's s_data_ok is still delivered.
- OUTSTANDING=2, m_data_ok delayed: two accepted, third request pending -> m_req=0 until a pop; re-asserted the cycle after m_data_ok.
- resetn pulled low while in HOLD_L with 1 entry in flight -> all outputs 0 immediately; a subsequent stray m_data_ok is ignored.
